flag_hazard_ctrl: RTL

Scheduler for the carry/zero flag path of the 16-bit RISC pipeline. Tracks flag-writing instructions through the EX, MEM and WB stages and forwards the youngest valid C/Z to a conditional consumer (ADC/ADZ-class) at issue. Raises a one-cycle interlock when a load's late Z flag is not yet available, and commits the architectural C/Z at WB. Replaces ad-hoc flag shifting in the datapath.

---
 rtl/flag_pkg.sv | 28 ++
 rtl/flag_fwd_mux.sv | 24 ++
 rtl/flag_hazard_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/flag_pkg.sv
// Purpose: shared types for the C/Z flag hazard scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: flag_entry_t pipeline entry, state_t interlock FSM, BUBBLE constant.
package flag_pkg;

  // One flag-writing instruction tracked through EX/MEM/WB.
  //   v  : entry holds a live instruction
  //   wc : writes C        wz : writes Z
  //   c,z: flag values captured at the end of EX (z is stale while zl=1)
  //   zl : Z is produced in MEM (load) and not yet captured
  typedef struct packed {
    logic v;
    logic wc;
    logic wz;
    logic c;
    logic z;
    logic zl;
  } flag_entry_t;

  typedef enum logic {
    RUN  = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam flag_entry_t BUBBLE = '0;

endpackage

// File: rtl/flag_fwd_mux.sv
// Purpose: per-flag forwarding priority resolver, youngest producer wins.
// Latency: purely combinational.
// Backpressure: none; output follows inputs every cycle.
// Ports: *_hit_i qualify a stage as a writer of this flag, *_val_i carry its value,
//        arch_val_i is the committed fallback, flag_o the resolved value.
module flag_fwd_mux (
  input  logic ex_hit_i,
  input  logic ex_val_i,
  input  logic mem_hit_i,
  input  logic mem_val_i,
  input  logic wb_hit_i,
  input  logic wb_val_i,
  input  logic arch_val_i,
  output logic flag_o
);

  always_comb begin
    if (ex_hit_i)       flag_o = ex_val_i;
    else if (mem_hit_i) flag_o = mem_val_i;
    else if (wb_hit_i)  flag_o = wb_val_i;
    else                flag_o = arch_val_i;
  end

endmodule

// File: rtl/flag_hazard_ctrl.sv
// Purpose: tracks C/Z writers through EX/MEM/WB, forwards youngest C/Z, commits at WB.
// Latency: forwarding combinational; commit on the 3rd advancing edge after issue.
// Backpressure: stall_in_i freezes all state; interlock_o holds issue one cycle for a late Z.
// Ports: clk_i/rst_n_i (sync, active-low), stall_in_i, flush_i, iss_* (entry into EX),
//        ex_c_i/ex_z_i (EX ALU flags), mem_z_i (late Z of MEM entry), cons_* (issue consumer),
//        fwd_c_o/fwd_z_o, interlock_o, arch_c_o/arch_z_o, prev_c_o/prev_z_o (FLAG_HIST_EN only).
// Optional feature macro: FLAG_HIST_EN adds the committed-flag history outputs.
module flag_hazard_ctrl #(
  parameter int HIST_DEPTH = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic stall_in_i,
  input  logic flush_i,
  input  logic iss_valid_i,
  input  logic iss_wr_c_i,
  input  logic iss_wr_z_i,
  input  logic iss_z_late_i,
  input  logic ex_c_i,
  input  logic ex_z_i,
  input  logic mem_z_i,
  input  logic cons_valid_i,
  input  logic cons_rd_c_i,
  input  logic cons_rd_z_i,
  output logic fwd_c_o,
  output logic fwd_z_o,
  output logic interlock_o,
  output logic arch_c_o,
  output logic arch_z_o
`ifdef FLAG_HIST_EN
  ,
  output logic [HIST_DEPTH-1:0] prev_c_o,
  output logic [HIST_DEPTH-1:0] prev_z_o
`endif
);

  import flag_pkg::*;

  flag_entry_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, iss_e;
  state_t      state_q;
  logic        arch_c_q, arch_c_d, arch_z_q, arch_z_d;
  logic        advance, interlock;
  logic        ex_c_hit, mem_c_hit, wb_c_hit;
  logic        ex_z_hit, mem_z_hit, wb_z_hit;
  logic        mem_z_val;

  // C always comes out of EX, so a C read never needs to wait.
  logic unused_cons_rd_c;
  assign unused_cons_rd_c = cons_rd_c_i;

  assign advance = !stall_in_i;

  assign ex_c_hit  = ex_q.v  & ex_q.wc;
  assign mem_c_hit = mem_q.v & mem_q.wc;
  assign wb_c_hit  = wb_q.v  & wb_q.wc;
  assign ex_z_hit  = ex_q.v  & ex_q.wz;
  assign mem_z_hit = mem_q.v & mem_q.wz;
  assign wb_z_hit  = wb_q.v  & wb_q.wz;

  // A load in MEM delivers its Z this cycle on mem_z_i.
  assign mem_z_val = mem_q.zl ? mem_z_i : mem_q.z;

  // Youngest Z writer is a load still in EX: its Z does not exist yet.
  // A flush kills that load, so it also cancels the interlock.
  assign interlock = cons_valid_i & cons_rd_z_i & ex_z_hit & ex_q.zl
                   & (state_q == RUN) & !flush_i;
  assign interlock_o = interlock;

  flag_fwd_mux u_fwd_c (
    .ex_hit_i   (ex_c_hit),
    .ex_val_i   (ex_c_i),
    .mem_hit_i  (mem_c_hit),
    .mem_val_i  (mem_q.c),
    .wb_hit_i   (wb_c_hit),
    .wb_val_i   (wb_q.c),
    .arch_val_i (arch_c_q),
    .flag_o     (fwd_c_o)
  );

  flag_fwd_mux u_fwd_z (
    .ex_hit_i   (ex_z_hit),
    .ex_val_i   (ex_z_i),
    .mem_hit_i  (mem_z_hit),
    .mem_val_i  (mem_z_val),
    .wb_hit_i   (wb_z_hit),
    .wb_val_i   (wb_q.z),
    .arch_val_i (arch_z_q),
    .flag_o     (fwd_z_o)
  );

  always_comb begin
    iss_e    = BUBBLE;
    iss_e.v  = iss_valid_i;
    iss_e.wc = iss_wr_c_i;
    iss_e.wz = iss_wr_z_i;
    iss_e.zl = iss_z_late_i;

    ex_d     = ex_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    arch_c_d = arch_c_q;
    arch_z_d = arch_z_q;

    if (advance) begin
      wb_d = mem_q;
      if (mem_q.zl) begin
        wb_d.z  = mem_z_i;
        wb_d.zl = 1'b0;
      end
      // A flushed EX entry moves on as a bubble so it can never commit.
      mem_d   = ex_q;
      mem_d.v = ex_q.v & !flush_i;
      mem_d.c = ex_c_i;
      mem_d.z = ex_z_i;
      ex_d    = interlock ? BUBBLE : iss_e;
      if (wb_q.v) begin
        if (wb_q.wc) arch_c_d = wb_q.c;
        if (wb_q.wz) arch_z_d = wb_q.z;
      end
    end
    // The EX slot is killed even while the rest of the pipe is frozen.
    if (flush_i) ex_d = BUBBLE;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ex_q     <= BUBBLE;
      mem_q    <= BUBBLE;
      wb_q     <= BUBBLE;
      arch_c_q <= 1'b0;
      arch_z_q <= 1'b0;
      state_q  <= RUN;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      arch_c_q <= arch_c_d;
      arch_z_q <= arch_z_d;
      if (flush_i) begin
        state_q <= RUN;
      end else if (advance) begin
        case (state_q)
          RUN:     state_q <= interlock ? LOCK : RUN;
          LOCK:    state_q <= RUN;
          default: state_q <= RUN;
        endcase
      end
    end
  end

  assign arch_c_o = arch_c_q;
  assign arch_z_o = arch_z_q;

`ifdef FLAG_HIST_EN
  logic [HIST_DEPTH-1:0] prev_c_q, prev_z_q;
  logic [HIST_DEPTH:0]   hist_c_sh, hist_z_sh;

  // arch_*_d already holds the committed value, or the unchanged arch
  // value for an entry that does not write that flag.
  assign hist_c_sh = {prev_c_q, arch_c_d};
  assign hist_z_sh = {prev_z_q, arch_z_d};

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      prev_c_q <= '0;
      prev_z_q <= '0;
    end else if (advance && wb_q.v) begin
      prev_c_q <= hist_c_sh[HIST_DEPTH-1:0];
      prev_z_q <= hist_z_sh[HIST_DEPTH-1:0];
    end
  end

  assign prev_c_o = prev_c_q;
  assign prev_z_o = prev_z_q;
`else
  localparam int unused_hist_depth = HIST_DEPTH;
`endif

endmodule
